// File: rtl/power_stim_sequencer_pkg.sv
// power_stim_sequencer_pkg: mode codes, FSM state encodings and default LFSR constants.
package power_stim_sequencer_pkg;

    typedef enum logic [1:0] {
        M_FIXED  = 2'd0,
        M_RANDOM = 2'd1,
        M_ALT    = 2'd2,
        M_RSEL   = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    localparam logic [31:0] DEF_SEED = 32'hACE1ACE1;
    localparam logic [31:0] DEF_TAPS = 32'h80200003;

endpackage

// File: rtl/power_stim_sequencer_lfsr_gen.sv
// power_stim_sequencer_lfsr_gen: Fibonacci LFSR that advances one step per step pulse.
module power_stim_sequencer_lfsr_gen
    import power_stim_sequencer_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEF_SEED),
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(DEF_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [DATA_W-1:0] state
);

    logic [DATA_W-1:0] state_q, state_d;

    // A stuck all-zero state is recovered by reloading the seed.
    always_comb state_d = ~|state_q ? SEED : {state_q[DATA_W-2:0], ^(state_q & TAPS)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SEED;
        else if (step) state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/power_stim_sequencer.sv
// power_stim_sequencer: drives a clr/start/busy cipher core with fixed/LFSR plaintexts,
// programmable inter-op gap, scope trigger and a per-op fixed/random class label.
module power_stim_sequencer
    import power_stim_sequencer_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(DEF_SEED),
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEF_TAPS),
    parameter int                GAP_W     = 8,
    parameter int                COUNT_W   = 16,
    parameter int                BUSY_TMO  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [DATA_W-1:0]  fixed_text,
    input  logic [GAP_W-1:0]   gap_cycles,
    input  logic               dut_busy,
    output logic               dut_clr,
    output logic               dut_start,
    output logic [DATA_W-1:0]  dut_text,
    output logic               trigger,
    output logic               is_fixed,
    output logic               done,
    output logic               timeout,
    output logic [COUNT_W-1:0] op_count
);

    localparam int TMO_W = $clog2(BUSY_TMO + 1);

    state_t             state_q;
    logic [GAP_W-1:0]   gap_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [DATA_W-1:0]  text_q, lfsr;
    logic [COUNT_W-1:0] ops_q;
    logic               toggle_q, clr_q, start_q, done_q, timeout_q, fixed_q;
    logic               step, pick_fixed, op_end;
    mode_t              mode_m;

    assign mode_m = mode_t'(mode);

    always_comb begin
        pick_fixed = (mode_m == M_FIXED) ? 1'b1 : (mode_m == M_RANDOM) ? 1'b0 :
                     (mode_m == M_ALT) ? ~toggle_q : lfsr[0];
        step = (state_q == S_LOAD) &&
               ((mode_m == M_RANDOM) || (mode_m == M_RSEL) || ((mode_m == M_ALT) && toggle_q));
        // An op ends either on busy falling or on busy never rising within the timeout window.
        op_end = ~dut_busy && ((state_q == S_WAIT_DONE) ||
                 ((state_q == S_WAIT_BUSY) && (tmo_q == TMO_W'(BUSY_TMO - 1))));
    end

    power_stim_sequencer_lfsr_gen #(
        .DATA_W (DATA_W),
        .SEED   (LFSR_SEED),
        .TAPS   (LFSR_TAPS)
    ) u_lfsr_gen (
        .clk   (clk),
        .rst   (rst),
        .step  (step),
        .state (lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            tmo_q     <= '0;
            text_q    <= '0;
            ops_q     <= '0;
            toggle_q  <= 1'b0;
            clr_q     <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            fixed_q   <= 1'b0;
        end else begin
            clr_q   <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clr_q <= enable;
                    if (enable) state_q <= S_CLEAR;
                end
                S_CLEAR: state_q <= S_LOAD;
                S_LOAD: begin
                    state_q <= S_START;
                    start_q <= 1'b1;
                    text_q  <= pick_fixed ? fixed_text : lfsr;
                    fixed_q <= pick_fixed;
                    if (mode_m == M_ALT) toggle_q <= ~toggle_q;
                end
                S_START: begin
                    state_q <= S_WAIT_BUSY;
                    tmo_q   <= '0;
                end
                S_WAIT_BUSY: begin
                    if (dut_busy) state_q <= S_WAIT_DONE;
                    else if (op_end) timeout_q <= 1'b1;
                    else tmo_q <= tmo_q + TMO_W'(1);
                end
                S_WAIT_DONE: ;
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= enable ? S_CLEAR : S_IDLE;
                        clr_q   <= enable;
                    end else gap_q <= gap_q - GAP_W'(1);
                end
                default: state_q <= S_IDLE;
            endcase
            if (op_end) begin
                state_q <= S_GAP;
                gap_q   <= gap_cycles;
                done_q  <= 1'b1;
                if (~&ops_q) ops_q <= ops_q + COUNT_W'(1);
            end
        end
    end

    assign dut_clr   = clr_q;
    assign dut_start = start_q;
    assign trigger   = start_q;
    assign dut_text  = text_q;
    assign is_fixed  = fixed_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign op_count  = ops_q;

endmodule

// File: tb/tb_power_stim_sequencer.sv
// tb_power_stim_sequencer: plans each session as an op timeline from the sequencing rules,
// then compares every cycle of the DUT (and a COUNT_W=2 copy) against that timeline.
module tb_power_stim_sequencer;

    localparam int          MAXN = 3400;
    localparam logic [31:0] SEED = 32'hACE1ACE1;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, dut_busy = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] fixed_text = '0;
    logic [7:0]  gap_cycles = '0;
    logic        clr, start, trig, isf, done, tmo;
    logic [31:0] text;
    logic [15:0] ops;
    logic        s_clr, s_start, s_trig, s_isf, s_done, s_tmo;
    logic [31:0] s_text;
    logic [1:0]  sops;
    logic [55:0] actv;
    int          ntests = 0, nfail = 0;

    bit          en_a[MAXN], bz_a[MAXN];
    logic [1:0]  md_a[MAXN];
    logic [31:0] ft_a[MAXN];
    logic [7:0]  gp_a[MAXN];
    bit          e_clr[MAXN], e_start[MAXN], e_done[MAXN], e_tmo[MAXN], e_isf[MAXN];
    logic [31:0] e_text[MAXN];
    int          e_ops[MAXN];
    bit          ev_set[MAXN], ev_f[MAXN], ev_tmo[MAXN];
    logic [31:0] ev_txt[MAXN];

    power_stim_sequencer u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .fixed_text(fixed_text),
        .gap_cycles(gap_cycles), .dut_busy(dut_busy), .dut_clr(clr), .dut_start(start),
        .dut_text(text), .trigger(trig), .is_fixed(isf), .done(done), .timeout(tmo),
        .op_count(ops)
    );

    power_stim_sequencer #(.COUNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .fixed_text(fixed_text),
        .gap_cycles(gap_cycles), .dut_busy(dut_busy), .dut_clr(s_clr), .dut_start(s_start),
        .dut_text(s_text), .trigger(s_trig), .is_fixed(s_isf), .done(s_done), .timeout(s_tmo),
        .op_count(sops)
    );

    always #5 clk = ~clk;

    assign actv = {clr, start, trig, done, tmo, isf, text, ops, sops};

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return (s == 0) ? SEED : {s[30:0], ^(s & TAPS)};
    endfunction

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    function automatic logic [55:0] expv(input int i);
        return {e_clr[i], e_start[i], e_start[i], e_done[i], e_tmo[i], e_isf[i], e_text[i],
                16'(e_ops[i]), sat2(e_ops[i])};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        ntests++;
        if (act !== want) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Literal expectation checked against both the DUT and the bench's own timeline.
    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] mdl,
                       input logic [63:0] want);
        chk(nm, act, want);
        chk({"model_", nm}, mdl, want);
    endtask

    // kind 0..4 are the directed scenarios, kind 5 is fully randomized.
    task automatic plan(input int kind, input int n);
        int t, c, x, d, l, k, opn, ocnt;
        logic [31:0] lf, txt, fx, ctxt;
        bit tog, f, run, cf, ct;
        for (int i = 0; i < MAXN; i++) begin
            en_a[i] = (kind == 4) ? (i < 18) : (kind == 5) ? ($urandom_range(99) < 85) : 1'b1;
            md_a[i] = (kind == 0 || kind == 3) ? 2'd1 : (kind == 1) ? ((i < 19) ? 2'd0 : 2'd1) :
                      (kind == 2) ? 2'd2 : 2'($urandom_range(3));
            ft_a[i] = (kind == 1 || kind == 2) ? 32'hDEADBEEF : $urandom;
            gp_a[i] = (kind == 4) ? 8'd5 : (kind != 5) ? 8'd0 :
                      ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(7));
            bz_a[i] = 1'($urandom_range(1));
            {e_clr[i], e_start[i], e_done[i], ev_set[i], ev_f[i], ev_tmo[i]} = '0;
            ev_txt[i] = '0;
        end
        lf = SEED; tog = 0; t = 0; opn = 0;
        while (t < n) begin
            c = t;
            while (c < n && !en_a[c]) c++;
            if (c >= n) break;
            c++;
            run = 1;
            while (run && c < n) begin
                e_clr[c] = 1;
                fx = ft_a[c + 1];
                case (md_a[c + 1])
                    2'd0: begin txt = fx; f = 1; end
                    2'd1: begin txt = lf; f = 0; lf = lstep(lf); end
                    2'd2: begin f = !tog; txt = f ? fx : lf; if (!f) lf = lstep(lf); tog = !tog; end
                    default: begin f = lf[0]; txt = f ? fx : lf; lf = lstep(lf); end
                endcase
                ev_set[c + 2] = 1; ev_txt[c + 2] = txt; ev_f[c + 2] = f; e_start[c + 2] = 1;
                case (kind)
                    0: begin d = 4; l = 2; end
                    1, 2: begin d = 1; l = 1; end
                    3: begin d = (opn == 0) ? 0 : 1; l = 1; end
                    4: begin d = 1; l = 3; end
                    default: begin d = $urandom_range(4); l = $urandom_range(4, 1); end
                endcase
                if (d == 0) begin
                    for (int j = c + 3; j <= c + 6; j++) bz_a[j] = 0;
                    x = c + 6;
                    ev_tmo[x + 1] = 1;
                end else begin
                    for (int j = c + 3; j <= c + 2 + d + l; j++) bz_a[j] = (j >= c + 2 + d) && (j < c + 2 + d + l);
                    x = c + 2 + d + l;
                end
                e_done[x + 1] = 1;
                opn++;
                k = x + 1 + int'(gp_a[x]);
                if (en_a[k]) c = k + 1;
                else begin run = 0; t = k + 1; end
            end
            if (run) break;
        end
        ctxt = '0; cf = 0; ct = 0; ocnt = 0;
        for (int i = 0; i < n; i++) begin
            if (ev_set[i]) begin ctxt = ev_txt[i]; cf = ev_f[i]; end
            if (e_done[i]) ocnt++;
            if (ev_tmo[i]) ct = 1;
            e_text[i] = ctxt; e_isf[i] = cf; e_tmo[i] = ct; e_ops[i] = ocnt;
        end
    endtask

    task automatic lits(input int kind, input int i);
        logic [31:0] ctx[4];
        bit          cfx[4];
        ctx = '{32'hDEADBEEF, 32'hACE1ACE1, 32'hDEADBEEF, 32'h59C359C3};
        cfx = '{1'b1, 1'b0, 1'b1, 1'b0};
        case (kind)
            0: begin
                if (i == 0) lit("reset_outputs", actv, expv(i), 0);
                if (i == 2) lit("start_not_early", start, e_start[i], 0);
                if (i == 3) begin
                    lit("start_latency3", start, e_start[i], 1);
                    lit("trigger_with_start", trig, e_start[i], 1);
                    lit("first_random_text", text, e_text[i], 32'hACE1ACE1);
                end
                if (i == 10) lit("done_pulse", done, e_done[i], 1);
                if (i == 11) lit("done_one_cycle", done, e_done[i], 0);
                if (i == 13) lit("second_random_text", text, e_text[i], 32'h59C359C3);
                if (i == 50) begin
                    lit("op_count5", ops, e_ops[i], 5);
                    lit("op_count_saturated", sops, sat2(e_ops[i]), 3);
                end
            end
            1: begin
                if (i == 3 || i == 9 || i == 15) begin
                    lit("fixed_text", text, e_text[i], 32'hDEADBEEF);
                    lit("fixed_class", isf, e_isf[i], 1);
                end
                if (i == 18) lit("op_count3", ops, e_ops[i], 3);
                if (i == 21) lit("lfsr_held_in_fixed", text, e_text[i], 32'hACE1ACE1);
            end
            2: if (i % 6 == 3 && i <= 21) begin
                lit($sformatf("alt_text%0d", i / 6), text, e_text[i], ctx[i / 6]);
                lit($sformatf("alt_class%0d", i / 6), isf, e_isf[i], 64'(cfx[i / 6]));
            end
            3: begin
                if (i == 7) lit("timeout_not_early", tmo, e_tmo[i], 0);
                if (i == 8) begin
                    lit("timeout_set", tmo, e_tmo[i], 1);
                    lit("timeout_done", done, e_done[i], 1);
                    lit("timeout_counted", ops, e_ops[i], 1);
                end
                if (i == 11) lit("continues_after_timeout", start, e_start[i], 1);
                if (i == 29) lit("timeout_sticky", tmo, e_tmo[i], 1);
            end
            4: begin
                if (i == 13) lit("gap_no_early_clr", clr, e_clr[i], 0);
                if (i == 14) lit("gap5_clr", clr, e_clr[i], 1);
                if (i == 21) begin
                    lit("drop_enable_done", done, e_done[i], 1);
                    lit("drop_enable_count", ops, e_ops[i], 2);
                end
                if (i == 39) lit("idle_after_drop", ops, e_ops[i], 2);
            end
            default: ;
        endcase
    endtask

    task automatic run(input int kind, input int n);
        plan(kind, n);
        rst = 1; enable = 0; dut_busy = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            enable = en_a[i]; mode = md_a[i]; fixed_text = ft_a[i];
            gap_cycles = gp_a[i]; dut_busy = bz_a[i];
            chk($sformatf("cycle%0d_kind%0d", i, kind), actv, expv(i));
            lits(kind, i);
        end
        if (kind == 0) begin
            // Session 0 ends in WAIT_DONE; reset must clear outputs without a clock edge.
            #1 rst = 1;
            #1 chk("async_reset_mid_op", {actv, s_clr, s_start}, 0);
        end
    endtask

    initial begin
        run(0, 59);
        run(2, 30);
        run(1, 30);
        run(3, 30);
        run(4, 40);
        for (int s = 0; s < 4; s++) run(5, 3000);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
